conv_18_acc_sat: RTL

Streaming accumulate-and-requantize stage placed directly downstream of the conv_18 signed 16x8 multiplier. It consumes one 24-bit signed product per cycle, sums a fixed number of products per output pixel on top of a preloaded bias, then rounds, shifts and saturates the sum to a 16-bit signed activation. A valid/ack handshake on both sides lets the block stall the product stream while a result waits to be taken.

---
 rtl/conv_18_acc_sat.sv | 106 ++++++++++
 1 files changed

// File: rtl/conv_18_acc_sat.sv
// Accumulate NUM_TERMS signed products on a shifted bias, then round, shift and saturate to int16.
// Optional `CONV_18_ACC_RELU_EN clamps negative results to zero after saturation.
module conv_18_acc_sat #(
   parameter int NUM_TERMS  = 9,
   parameter int OUT_SHIFT  = 8,
   parameter int BIAS_SHIFT = 8
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic signed [15:0] bias,
   input  logic signed [23:0] prod_dout,
   input  logic               prod_vld,
   output logic               prod_ack,
   output logic signed [15:0] res_dout,
   output logic               res_vld,
   input  logic               res_ack,
   output logic               res_ovf
);

   typedef enum logic {ACC, OUT} state_t;

   typedef struct packed {
      logic signed [15:0] dout;
      logic               ovf;
   } res_t;

   localparam logic [8:0]         LAST = 9'(NUM_TERMS - 1);
   localparam logic signed [32:0] RND  = (OUT_SHIFT > 0) ?
                                         (33'sd1 <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : 33'sd0;

   state_t             state, state_nxt;
   logic [8:0]         cnt;
   logic signed [31:0] acc;
   logic signed [31:0] bias_ext, base, sum;
   logic signed [32:0] sum33, r;
   logic               take, last;
   res_t               res_q, res_nxt;

   assign prod_ack = (state == ACC) && ap_rst_n;
   assign take     = prod_ack && prod_vld;
   assign last     = (cnt == LAST);

   // The first product of a group restarts from the shifted bias, discarding acc.
   always_comb begin
      bias_ext = {{16{bias[15]}}, bias} <<< BIAS_SHIFT;
      base     = (cnt == 9'd0) ? bias_ext : acc;
      sum      = base + {{8{prod_dout[23]}}, prod_dout};
      sum33    = {sum[31], sum};
      r        = (sum33 + RND) >>> OUT_SHIFT;
      res_nxt.ovf  = 1'b0;
      res_nxt.dout = r[15:0];
      if (r > 33'sd32767) begin
         res_nxt.dout = 16'sh7FFF;
         res_nxt.ovf  = 1'b1;
      end else if (r < -33'sd32768) begin
         res_nxt.dout = -16'sh8000;
         res_nxt.ovf  = 1'b1;
      end
`ifdef CONV_18_ACC_RELU_EN
      if (res_nxt.dout[15]) begin
         res_nxt.dout = 16'sh0000;
         res_nxt.ovf  = 1'b0;
      end
`endif
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) state <= ACC;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC: if (take && last) state_nxt = OUT;
         OUT: if (res_ack)      state_nxt = ACC;
         default:               state_nxt = ACC;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt     <= '0;
         acc     <= '0;
         res_q   <= '0;
         res_vld <= 1'b0;
      end else begin
         if (take) begin
            if (last) begin
               cnt     <= '0;
               acc     <= sum;
               res_q   <= res_nxt;
               res_vld <= 1'b1;
            end else begin
               cnt <= cnt + 9'd1;
               acc <= sum;
            end
         end
         if (state == OUT && res_ack) res_vld <= 1'b0;
      end
   end

   assign res_dout = res_q.dout;
   assign res_ovf  = res_q.ovf;

endmodule
